lock_supervisor: RTL and testbench

Supervisory controller that sits between the raw push-buttons and the two-button combination-lock FSM. It synchronises and debounces the buttons into single-cycle `b0`/`b1` pulses and forwards them to the lock. It watches the lock's state and open outputs, counts failed attempts, and enforces a timed lockout after too many failures. It re-arms the lock automatically after an open period and drives the board's status hex digit.

---
 rtl/lock_supervisor.sv | 214 +++++++++++++++++++++
 tb/tb_lock_supervisor.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lock_supervisor.sv
`default_nettype none
// ============================================================================
//  Module   : lock_supervisor
//  Purpose  : Conditions the two raw push-buttons into single-cycle press
//             pulses for the combination lock. Counts failed attempts and
//             enforces a timed lockout. Relocks the lock after an open
//             period and drives the status hex digit.
//  Revision : 1.0  initial release
// ============================================================================
module lock_supervisor #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int MAX_FAILS       = 3,
   parameter int LOCKOUT_CYCLES  = 16,
   parameter int OPEN_CYCLES     = 8
) (
   input  logic       clk,
   input  logic       reset_in,
   input  logic       btn0_raw,
   input  logic       btn1_raw,
   input  logic [3:0] lock_state,
   input  logic       lock_open,
   output logic       b0_out,
   output logic       b1_out,
   output logic       lock_reset_out,
   output logic       unlocked,
   output logic       lockout,
   output logic [3:0] fail_count,
   output logic [3:0] status_hex
);

   // The debounce counter only needs to reach DEBOUNCE_CYCLES-1 before the level flips
   localparam int                c_DB_W     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [c_DB_W-1:0] c_DB_LAST  = c_DB_W'(DEBOUNCE_CYCLES - 1);
   localparam int                c_TMR_MAX  = (LOCKOUT_CYCLES > OPEN_CYCLES) ? LOCKOUT_CYCLES : OPEN_CYCLES;
   localparam int                c_TMR_W    = $clog2(c_TMR_MAX + 1);
   localparam logic [c_TMR_W-1:0] c_T_LOCK  = c_TMR_W'(LOCKOUT_CYCLES);
   localparam logic [c_TMR_W-1:0] c_T_OPEN  = c_TMR_W'(OPEN_CYCLES);
   localparam logic [c_TMR_W-1:0] c_T_ONE   = c_TMR_W'(1);
   localparam logic [3:0]        c_MAX_FAIL = 4'(MAX_FAILS);

   typedef enum logic [1:0] {
      ST_ARMED   = 2'd0,
      ST_OPEN    = 2'd1,
      ST_LOCKOUT = 2'd2
   } state_t;

   logic [1:0]         w_raw;
   logic [1:0]         w_press;
   logic               w_both;
   logic               w_fail_lock;
   logic               w_fail;
   logic               w_open_rise;
   logic [3:0]         w_fail_next;

   state_t             r_state;
   logic [c_TMR_W-1:0] r_timer;
   logic [3:0]         r_fail;
   logic               r_b0;
   logic               r_b1;
   logic               r_lock_reset;
   logic               r_post_rst;
   logic               r_unlocked;
   logic               r_lockout;
   logic [3:0]         r_status;
   logic [3:0]         r_prev_state;
   logic               r_prev_open;

   assign w_raw = {btn1_raw, btn0_raw};

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_btn
         logic              r_sync1;
         logic              r_sync2;
         logic              r_lvl;
         logic              r_lvl_d;
         logic [c_DB_W-1:0] r_cnt;

         // Synchronise, then accept a new level only after a full run of mismatching samples
         always_ff @(posedge clk) begin
            if (reset_in) begin
               r_sync1 <= 1'b0;
               r_sync2 <= 1'b0;
               r_lvl   <= 1'b0;
               r_lvl_d <= 1'b0;
               r_cnt   <= '0;
            end else begin
               r_sync1 <= w_raw[gi];
               r_sync2 <= r_sync1;
               r_lvl_d <= r_lvl;
               if (r_sync2 != r_lvl) begin
                  if (r_cnt == c_DB_LAST) begin
                     r_lvl <= r_sync2;
                     r_cnt <= '0;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end else begin
                  r_cnt <= '0;
               end
            end
         end

         // Only a rising debounced level is a press
         assign w_press[gi] = r_lvl & ~r_lvl_d;
      end
   endgenerate

   // Event decode. While the lock is being reset its sampled outputs are stale, so ignore them
   always_comb begin
      w_both      = w_press[0] & w_press[1];
      w_fail_lock = ~r_lock_reset
                    & ((r_prev_state == 4'd2) | (r_prev_state == 4'd3) | (r_prev_state == 4'd4))
                    & ((lock_state == 4'd0) | (lock_state == 4'd1));
      w_fail      = w_fail_lock | w_both;
      w_open_rise = ~r_lock_reset & lock_open & ~r_prev_open;
      w_fail_next = r_fail + 4'd1;
   end

   // Supervisor state machine with all outputs registered
   always_ff @(posedge clk) begin
      if (reset_in) begin
         r_state      <= ST_ARMED;
         r_timer      <= '0;
         r_fail       <= 4'd0;
         r_b0         <= 1'b0;
         r_b1         <= 1'b0;
         r_lock_reset <= 1'b1;
         r_post_rst   <= 1'b1;
         r_unlocked   <= 1'b0;
         r_lockout    <= 1'b0;
         r_status     <= 4'h0;
         r_prev_state <= 4'd0;
         r_prev_open  <= 1'b0;
      end else begin
         r_post_rst   <= 1'b0;
         r_prev_state <= r_lock_reset ? 4'd0 : lock_state;
         r_prev_open  <= r_lock_reset ? 1'b0 : lock_open;
         r_b0         <= 1'b0;
         r_b1         <= 1'b0;
         unique case (r_state)
            ST_ARMED: begin
               // Keep the lock in reset for one extra cycle after our own reset
               r_lock_reset <= r_post_rst;
               r_status     <= r_lock_reset ? 4'h0 : lock_state;
               r_b0         <= w_press[0] & ~w_both;
               r_b1         <= w_press[1] & ~w_both;
               if (w_open_rise) begin
                  r_state    <= ST_OPEN;
                  r_fail     <= 4'd0;
                  r_timer    <= c_T_OPEN;
                  r_unlocked <= 1'b1;
                  r_status   <= 4'hA;
               end else if (w_fail && (r_fail < c_MAX_FAIL)) begin
                  r_fail <= w_fail_next;
                  if (w_fail_next == c_MAX_FAIL) begin
                     r_state      <= ST_LOCKOUT;
                     r_timer      <= c_T_LOCK;
                     r_lock_reset <= 1'b1;
                     r_lockout    <= 1'b1;
                     r_status     <= 4'hE;
                     r_b0         <= 1'b0;
                     r_b1         <= 1'b0;
                  end
               end
            end
            ST_OPEN: begin
               r_b0 <= w_press[0] & ~w_both;
               r_b1 <= w_press[1] & ~w_both;
               if ((r_timer == c_T_ONE) || !lock_open) begin
                  r_state      <= ST_ARMED;
                  r_timer      <= '0;
                  r_lock_reset <= 1'b1;
                  r_unlocked   <= 1'b0;
                  r_status     <= lock_state;
               end else begin
                  r_timer      <= r_timer - c_T_ONE;
                  r_lock_reset <= 1'b0;
                  r_status     <= 4'hA;
               end
            end
            ST_LOCKOUT: begin
               if (r_timer == c_T_ONE) begin
                  r_state      <= ST_ARMED;
                  r_timer      <= '0;
                  r_fail       <= 4'd0;
                  r_lock_reset <= 1'b0;
                  r_lockout    <= 1'b0;
                  r_status     <= 4'h0;
               end else begin
                  r_timer      <= r_timer - c_T_ONE;
                  r_lock_reset <= 1'b1;
                  r_status     <= 4'hE;
               end
            end
            default: begin
               r_state      <= ST_ARMED;
               r_lock_reset <= 1'b1;
               r_unlocked   <= 1'b0;
               r_lockout    <= 1'b0;
            end
         endcase
      end
   end

   assign b0_out         = r_b0;
   assign b1_out         = r_b1;
   assign lock_reset_out = r_lock_reset;
   assign unlocked       = r_unlocked;
   assign lockout        = r_lockout;
   assign fail_count     = r_fail;
   assign status_hex     = r_status;

endmodule
`default_nettype wire

// File: tb/tb_lock_supervisor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lock_supervisor
//  Purpose  : Directed self-checking bench for lock_supervisor with a small
//             behavioural model of the two-button combination lock.
//  Revision : 1.0  initial release
// ============================================================================
module tb_lock_supervisor;

   logic       clk = 1'b0;
   logic       reset_in = 1'b1;
   logic       btn0_raw = 1'b0;
   logic       btn1_raw = 1'b0;
   logic [3:0] lock_s = 4'd0;
   logic       lock_open_w;
   logic       b0_out;
   logic       b1_out;
   logic       lock_reset_out;
   logic       unlocked;
   logic       lockout;
   logic [3:0] fail_count;
   logic [3:0] status_hex;

   int n_checks = 0;
   int n_errors = 0;
   int cnt_b0 = 0;
   int cnt_b1 = 0;
   int cnt_lockout = 0;

   // Expected button per lock state: b0,b1,b1,b0,b1
   localparam logic [7:0] c_CODE = 8'b0001_0110;

   lock_supervisor #(
      .DEBOUNCE_CYCLES(4),
      .MAX_FAILS      (3),
      .LOCKOUT_CYCLES (16),
      .OPEN_CYCLES    (8)
   ) dut (
      .clk           (clk),
      .reset_in      (reset_in),
      .btn0_raw      (btn0_raw),
      .btn1_raw      (btn1_raw),
      .lock_state    (lock_s),
      .lock_open     (lock_open_w),
      .b0_out        (b0_out),
      .b1_out        (b1_out),
      .lock_reset_out(lock_reset_out),
      .unlocked      (unlocked),
      .lockout       (lockout),
      .fail_count    (fail_count),
      .status_hex    (status_hex)
   );

   always #5 clk = ~clk;

   assign lock_open_w = (lock_s == 4'd5);

   // Lock model: right button advances, wrong b0 goes to 1, wrong b1 goes to 0
   always_ff @(posedge clk) begin
      if (lock_reset_out)
         lock_s <= 4'd0;
      else if (b0_out && b1_out)
         lock_s <= 4'd0;
      else if (b0_out)
         lock_s <= (lock_s < 4'd5 && !c_CODE[lock_s[2:0]]) ? lock_s + 4'd1 : 4'd1;
      else if (b1_out)
         lock_s <= (lock_s < 4'd5 && c_CODE[lock_s[2:0]]) ? lock_s + 4'd1 : 4'd0;
   end

   // Pulse and lockout-cycle counters
   always_ff @(posedge clk) begin
      if (b0_out)  cnt_b0      <= cnt_b0 + 1;
      if (b1_out)  cnt_b1      <= cnt_b1 + 1;
      if (lockout) cnt_lockout <= cnt_lockout + 1;
   end

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   // Raw press held 8 cycles; pulse expected exactly 6 edges after first sample
   task automatic press(input bit which, input bit exp);
      if (which) btn1_raw = 1'b1; else btn0_raw = 1'b1;
      idle(6);
      check("pulse_early", int'(which ? b1_out : b0_out), 0);
      tick();
      check("pulse", int'(which ? b1_out : b0_out), int'(exp));
      tick();
      check("pulse_width", int'(which ? b1_out : b0_out), 0);
      btn0_raw = 1'b0;
      btn1_raw = 1'b0;
   endtask

   // b0,b1,b1,b1: lock reaches 3 then falls to 0 -> one failure
   task automatic wrong_seq();
      press(1'b0, 1'b1); idle(8);
      press(1'b1, 1'b1); idle(8);
      press(1'b1, 1'b1); idle(8);
      press(1'b1, 1'b1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n_open;
      int b0_snap;
      int b1_snap;

      // ---------------- reset ----------------
      idle(3);
      check("rst_lock_reset", int'(lock_reset_out), 1);
      check("rst_b0", int'(b0_out), 0);
      check("rst_unlocked", int'(unlocked), 0);
      check("rst_lockout", int'(lockout), 0);
      check("rst_fail", int'(fail_count), 0);
      check("rst_status", int'(status_hex), 0);
      reset_in = 1'b0;
      tick();
      check("post_rst_lock_reset", int'(lock_reset_out), 1);
      check("post_rst_status", int'(status_hex), 0);
      tick();
      check("post_rst_release", int'(lock_reset_out), 0);
      idle(4);

      // ---------------- correct code ----------------
      press(1'b0, 1'b1); idle(8);
      press(1'b1, 1'b1); idle(8);
      press(1'b1, 1'b1); idle(8);
      press(1'b0, 1'b1); idle(2);
      check("status_armed_state4", int'(status_hex), 4);
      idle(6);
      press(1'b1, 1'b1);
      check("not_yet_open", int'(unlocked), 0);
      n_open = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (unlocked) begin
            n_open++;
            if (n_open == 1) check("status_open", int'(status_hex), 10);
         end else if (n_open > 0) begin
            break;
         end
      end
      check("open_cycles", n_open, 8);
      check("relock_pulse", int'(lock_reset_out), 1);
      tick();
      check("relock_pulse_end", int'(lock_reset_out), 0);
      check("status_after_relock", int'(status_hex), 0);
      idle(6);

      // ---------------- bounce ----------------
      b0_snap = cnt_b0;
      btn0_raw = 1'b1; idle(3);
      btn0_raw = 1'b0; idle(1);
      btn0_raw = 1'b1; idle(3);
      btn0_raw = 1'b0; idle(12);
      check("bounce_no_pulse", cnt_b0 - b0_snap, 0);
      press(1'b0, 1'b1); idle(8);
      check("bounce_then_one", cnt_b0 - b0_snap, 1);

      // held button -> exactly one pulse
      b0_snap = cnt_b0;
      btn0_raw = 1'b1; idle(30);
      btn0_raw = 1'b0; idle(10);
      check("held_one_pulse", cnt_b0 - b0_snap, 1);

      // ---------------- lockout ----------------
      for (int k = 1; k <= 3; k++) begin
         wrong_seq();
         tick();
         check("fail_count_step", int'(fail_count), k);
         if (k < 3) idle(8);
      end
      check("lockout_on", int'(lockout), 1);
      check("lockout_lock_reset", int'(lock_reset_out), 1);
      tick();
      check("status_lockout", int'(status_hex), 14);
      press(1'b0, 1'b0);
      check("lockout_hold_reset", int'(lock_reset_out), 1);
      for (int i = 0; i < 30; i++) begin
         if (!lockout) break;
         tick();
      end
      check("lockout_exit", int'(lockout), 0);
      check("lockout_cycles", cnt_lockout, 16);
      check("lockout_fail_clear", int'(fail_count), 0);
      check("lockout_reset_drop", int'(lock_reset_out), 0);
      check("lockout_status_armed", int'(status_hex), 0);
      idle(8);

      // ---------------- simultaneous press ----------------
      b0_snap = cnt_b0;
      b1_snap = cnt_b1;
      btn0_raw = 1'b1;
      btn1_raw = 1'b1;
      idle(9);
      btn0_raw = 1'b0;
      btn1_raw = 1'b0;
      check("both_no_b0", cnt_b0 - b0_snap, 0);
      check("both_no_b1", cnt_b1 - b1_snap, 0);
      check("both_fail", int'(fail_count), 1);
      idle(8);

      // ---------------- early relock ----------------
      press(1'b0, 1'b1); idle(8);
      press(1'b1, 1'b1); idle(8);
      press(1'b1, 1'b1); idle(8);
      press(1'b0, 1'b1); idle(8);
      btn1_raw = 1'b1;
      tick();               // M: first sample of b1
      idle(3);
      btn0_raw = 1'b1;      // first sampled at M+4
      idle(3);
      check("early_b1_pulse", int'(b1_out), 1);
      tick();
      btn1_raw = 1'b0;
      tick();
      check("early_open", int'(unlocked), 1);
      check("early_fail_clear", int'(fail_count), 0);
      idle(2);
      check("early_b0_pulse", int'(b0_out), 1);
      tick();
      check("early_still_open", int'(unlocked), 1);
      tick();
      check("early_closed", int'(unlocked), 0);
      check("early_relock", int'(lock_reset_out), 1);
      btn0_raw = 1'b0;
      tick();
      check("early_relock_end", int'(lock_reset_out), 0);
      check("early_no_fail", int'(fail_count), 0);
      idle(8);

      // ---------------- reset mid-lockout ----------------
      for (int k = 1; k <= 3; k++) begin
         wrong_seq();
         tick();
         if (k < 3) idle(8);
      end
      check("lockout2_on", int'(lockout), 1);
      idle(4);
      reset_in = 1'b1;
      tick();
      check("midrst_lockout", int'(lockout), 0);
      check("midrst_fail", int'(fail_count), 0);
      check("midrst_lock_reset", int'(lock_reset_out), 1);
      check("midrst_status", int'(status_hex), 0);
      reset_in = 1'b0;
      tick();
      check("midrst_post_lock_reset", int'(lock_reset_out), 1);
      check("midrst_post_lockout", int'(lockout), 0);
      tick();
      check("midrst_release", int'(lock_reset_out), 0);
      idle(4);
      press(1'b0, 1'b1);
      idle(2);
      check("midrst_armed_status", int'(status_hex), 1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
